// File: rtl/tmg_conv_mac_if.sv
// Purpose : element/weight/result bundle between tmgall-side driver and tmg_conv_mac.
// Latency : n/a (wires only).
// Backpr. : tm_valid/tm_ready on the element stream, conv_valid/conv_ready on results.
// Ports   : w_load, w_data (kernel write); teomatrix, tm_valid, tm_ready (element stream);
//           conv_out, conv_valid, conv_ready (result); busy (window in progress).
//           master = stimulus side, slave = the MAC.
interface tmg_conv_mac_if #(
  parameter int DW = 8,
  parameter int AW = 20
);
  logic          w_load;
  logic [DW-1:0] w_data;
  logic [DW-1:0] teomatrix;
  logic          tm_valid;
  logic          tm_ready;
  logic [AW-1:0] conv_out;
  logic          conv_valid;
  logic          conv_ready;
  logic          busy;

  modport master (
    output w_load, w_data, teomatrix, tm_valid, conv_ready,
    input  tm_ready, conv_out, conv_valid, busy
  );

  modport slave (
    input  w_load, w_data, teomatrix, tm_valid, conv_ready,
    output tm_ready, conv_out, conv_valid, busy
  );
endinterface

// File: rtl/tmg_conv_mac.sv
// Purpose : KN-tap MAC over the serial teomatrix stream; one signed result per window.
// Latency : conv_valid rises the cycle after the KN-th accepted element.
// Backpr. : a result not taken (conv_valid && !conv_ready) drops tm_ready at once and
//           parks in HOLD until conv_ready; no element is accepted meanwhile.
// Ports   : clk, rst (sync, active high); bus = tmg_conv_mac_if.slave.
// Config  : define CONV_MAC_RELU_EN to clamp negative results to 0 at the output register.
module tmg_conv_mac #(
  parameter int DW = 8,
  parameter int KN = 9,
  parameter int AW = 20
) (
  input logic          clk,
  input logic          rst,
  tmg_conv_mac_if.slave bus
);

  localparam int TW = $clog2(KN);
  localparam int PW = 2 * DW + 1;  // product width: 9b unsigned-as-signed x DW signed

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

  state_t               state;
  logic [TW-1:0]        tap;
  logic [TW-1:0]        widx;
  logic signed [DW-1:0] w [KN];
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] conv_out_q;
  logic                 conv_valid_q;

  logic                 tm_ready_c;
  logic                 accept;
  logic signed [DW-1:0] w_sel;
  logic signed [PW-1:0] elem_x;
  logic signed [PW-1:0] w_x;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] prod_x;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] res;

  // Stall the stream the same cycle an untaken result is seen, and while a
  // reload is requested, so an element is never claimed and then thrown away.
  assign tm_ready_c = (state == RUN) && !(conv_valid_q && !bus.conv_ready) && !bus.w_load;
  assign accept     = bus.tm_valid && tm_ready_c;

  // Element is unsigned: zero-extend; weight is signed: sign-extend. The true
  // product fits in PW signed bits, so the truncated multiply is exact.
  assign w_sel  = w[tap];
  assign elem_x = {{(PW-DW){1'b0}}, bus.teomatrix};
  assign w_x    = {{(PW-DW){w_sel[DW-1]}}, w_sel};
  assign prod   = elem_x * w_x;
  assign prod_x = {{(AW-PW){prod[PW-1]}}, prod};
  assign sum    = acc + prod_x;

`ifdef CONV_MAC_RELU_EN
  assign res = sum[AW-1] ? '0 : sum;
`else
  assign res = sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tap          <= '0;
      widx         <= '0;
      acc          <= '0;
      conv_out_q   <= '0;
      conv_valid_q <= 1'b0;
      for (int i = 0; i < KN; i++) w[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          // The cycle that sees w_load already carries weight 0.
          if (bus.w_load) begin
            w[0]  <= bus.w_data;
            widx  <= TW'(1);
            state <= LOAD;
          end
        end

        LOAD: begin
          if (bus.w_load) begin
            w[widx] <= bus.w_data;
            if (widx == TW'(KN - 1)) begin
              widx  <= '0;
              state <= RUN;
            end else begin
              widx <= widx + 1'b1;
            end
          end else begin
            // Short load leaves a partial kernel; refuse to run on it.
            widx  <= '0;
            state <= IDLE;
          end
        end

        RUN, HOLD: begin
          if (bus.w_load) begin
            acc          <= '0;
            tap          <= '0;
            conv_valid_q <= 1'b0;
            w[0]         <= bus.w_data;
            widx         <= TW'(1);
            state        <= LOAD;
          end else if (state == HOLD) begin
            if (bus.conv_ready) begin
              conv_valid_q <= 1'b0;
              state        <= RUN;
            end
          end else begin
            if (conv_valid_q) begin
              if (bus.conv_ready) conv_valid_q <= 1'b0;
              else                state        <= HOLD;
            end
            // A window close overrides the clear above; KN>1 means it never
            // coincides with a pending result in practice.
            if (accept) begin
              if (tap == TW'(KN - 1)) begin
                conv_out_q   <= res;
                conv_valid_q <= 1'b1;
                acc          <= '0;
                tap          <= '0;
              end else begin
                acc <= sum;
                tap <= tap + 1'b1;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tm_ready   = tm_ready_c;
  assign bus.conv_out   = conv_out_q;
  assign bus.conv_valid = conv_valid_q;
  assign bus.busy       = (tap != '0);

endmodule

// File: tb/tb_tmg_conv_mac.sv
// Purpose : directed bench for tmg_conv_mac with hand-computed window sums.
// Latency : checks conv_valid one cycle after the 9th element and 9-cycle result spacing.
// Backpr. : checks tm_ready drop and conv_out stability while conv_ready is low.
module tb_tmg_conv_mac;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nmis = 0;
  int   cyc  = 0;
  int   t1, t2;
  int   neg_exp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  tmg_conv_mac_if #(.DW(8), .AW(20)) bus ();

  tmg_conv_mac #(.DW(8), .KN(9), .AW(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Weight i = base + step*i, one per cycle, starting on a falling edge.
  task automatic load(input int base, input int step, input int n);
    for (int i = 0; i < n; i++) begin
      bus.w_load = 1'b1;
      bus.w_data = 8'(base + step * i);
      @(negedge clk);
    end
    bus.w_load = 1'b0;
  endtask

  // Offer one element and wait (bounded) until it is taken.
  task automatic send(input int v);
    int n;
    n = 0;
    bus.tm_valid  = 1'b1;
    bus.teomatrix = 8'(v);
    #1;
    while (!bus.tm_ready && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.tm_ready) chk("send_timeout", 32'(bus.tm_ready), 32'd1);
    @(negedge clk);
    bus.tm_valid = 1'b0;
  endtask

  initial begin
    bus.w_load     = 1'b0;
    bus.w_data     = '0;
    bus.teomatrix  = '0;
    bus.tm_valid   = 1'b0;
    bus.conv_ready = 1'b1;
`ifdef CONV_MAC_RELU_EN
    neg_exp = 0;
`else
    neg_exp = -2295;
`endif

    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus.tm_valid = 1'b1;
    #1;
    chk("rst_conv_out",   32'(bus.conv_out),   32'd0);
    chk("rst_conv_valid", 32'(bus.conv_valid), 32'd0);
    chk("rst_tm_ready",   32'(bus.tm_ready),   32'd0);
    chk("rst_busy",       32'(bus.busy),       32'd0);
    bus.tm_valid = 1'b0;
    @(negedge clk);

    // 1: unit kernel, 1..9 -> 45, valid exactly after the 9th element
    load(1, 0, 9);
    for (int i = 1; i <= 8; i++) send(i);
    chk("t1_valid_early", 32'(bus.conv_valid), 32'd0);
    chk("t1_busy",        32'(bus.busy),       32'd1);
    send(9);
    chk("t1_valid", 32'(bus.conv_valid), 32'd1);
    chk("t1_out",   32'(bus.conv_out),   32'd45);
    chk("t1_busy_done", 32'(bus.busy),   32'd0);
    @(negedge clk);
    chk("t1_valid_clr", 32'(bus.conv_valid), 32'd0);

    // 2: w=1..9; 1..9 -> 285, then 9..1 -> 165, back to back
    load(1, 1, 9);
    for (int i = 1; i <= 9; i++) send(i);
    t1 = cyc;
    chk("t2_valid_a", 32'(bus.conv_valid), 32'd1);
    chk("t2_out_a",   32'(bus.conv_out),   32'd285);
    send(9);
    chk("t2_valid_clr", 32'(bus.conv_valid), 32'd0);
    chk("t2_busy",      32'(bus.busy),       32'd1);
    for (int i = 8; i >= 1; i--) send(i);
    t2 = cyc;
    chk("t2_valid_b", 32'(bus.conv_valid), 32'd1);
    chk("t2_out_b",   32'(bus.conv_out),   32'd165);
    chk("t2_spacing", 32'(t2 - t1),        32'd9);
    @(negedge clk);

    // 3: w=-1, nine 255s -> -2295, sign-extended across 20 bits
    load(255, 0, 9);
    for (int i = 0; i < 9; i++) send(255);
    chk("t3_valid", 32'(bus.conv_valid), 32'd1);
`ifdef CONV_MAC_RELU_EN
    chk("t3_out", 32'(bus.conv_out), 32'd0);
`else
    chk("t3_out", 32'(bus.conv_out), 32'h000F_F709);
`endif
    chk("t3_sext", 32'($signed(bus.conv_out)), 32'(neg_exp));
    @(negedge clk);

    // 4: backpressure; result must hold and the stream must stall
    load(1, 0, 9);
    bus.conv_ready = 1'b0;
    for (int i = 1; i <= 9; i++) send(i);
    bus.tm_valid  = 1'b1;
    bus.teomatrix = 8'd2;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4_tm_ready", 32'(bus.tm_ready),   32'd0);
      chk("t4_valid",    32'(bus.conv_valid), 32'd1);
      chk("t4_out",      32'(bus.conv_out),   32'd45);
      @(negedge clk);
    end
    bus.conv_ready = 1'b1;
    for (int i = 0; i < 9; i++) send(2);
    chk("t4_valid_next", 32'(bus.conv_valid), 32'd1);
    chk("t4_out_next",   32'(bus.conv_out),   32'd18);
    @(negedge clk);

    // 5: reset after element 4 wipes everything, kernel included
    for (int i = 1; i <= 4; i++) send(i);
    chk("t5_busy_pre", 32'(bus.busy),     32'd1);
    chk("t5_out_pre",  32'(bus.conv_out), 32'd18);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.tm_valid = 1'b1;
    #1;
    chk("t5_conv_out",   32'(bus.conv_out),   32'd0);
    chk("t5_conv_valid", 32'(bus.conv_valid), 32'd0);
    chk("t5_tm_ready",   32'(bus.tm_ready),   32'd0);
    chk("t5_busy",       32'(bus.busy),       32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("t5_tm_ready_idle", 32'(bus.tm_ready), 32'd0);
    bus.tm_valid = 1'b0;
    @(negedge clk);

    // 6: full load -> RUN; 5-cycle load -> IDLE; full reload (w=2) -> 90
    load(1, 0, 9);
    bus.tm_valid = 1'b1;
    #1;
    chk("t6_ready_run", 32'(bus.tm_ready), 32'd1);
    bus.tm_valid = 1'b0;
    @(negedge clk);
    load(3, 0, 5);
    bus.tm_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("t6_ready_short", 32'(bus.tm_ready), 32'd0);
    bus.tm_valid = 1'b0;
    @(negedge clk);
    load(2, 0, 9);
    for (int i = 1; i <= 9; i++) send(i);
    chk("t6_valid", 32'(bus.conv_valid), 32'd1);
    chk("t6_out",   32'(bus.conv_out),   32'd90);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
